// File: rtl/run_history_detector.sv
// run_history_detector: tracks the run length of identical symbols on a
// valid-qualified stream. It raises a Mealy repeat flag (x) and a
// programmable-threshold run flag (y) in the same cycle as the sample.
//
// Handshake: there is no backpressure. A sample is accepted on a rising
// clk edge when valid=1 and clear=0. clear=1 flushes the history and wins
// over valid. valid=0 cycles are gaps: they hold the history and do not
// break a run.
module run_history_detector #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,      // asynchronous, active-low
    input  logic [WIDTH-1:0] a,
    input  logic             valid,
    input  logic             clear,
    input  logic [CNT_W-1:0] threshold,
    output logic             x,
    output logic             y,
    output logic [CNT_W-1:0] run_len,
    output logic [WIDTH-1:0] run_val,
    output logic             dbg_state   // 1 = TRACK, 0 = EMPTY
);

    typedef enum logic {
        EMPTY = 1'b0,
        TRACK = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] last_val;
    logic [CNT_W-1:0] run_cnt;
    logic [CNT_W-1:0] cur_len;
    logic [CNT_W-1:0] thr_eff;
    logic             accept;
    logic             match;

    assign accept = valid & ~clear;

    // State register: EMPTY until the first accepted sample
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: clear flushes, an accepted sample starts or continues tracking
    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = EMPTY;
        end else if (valid) begin
            state_nxt = TRACK;
        end
    end

    // Current run length including this sample, saturating at the counter max
    always_comb begin
        match   = (state == TRACK) && (a == last_val);
        cur_len = CNT_ONE;
        if (match) begin
            cur_len = (run_cnt == CNT_MAX) ? CNT_MAX : run_cnt + CNT_ONE;
        end
    end

    // History datapath: last accepted symbol and its run length
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_val <= '0;
            run_cnt  <= '0;
        end else if (clear) begin
            last_val <= '0;
            run_cnt  <= '0;
        end else if (valid) begin
            last_val <= a;
            run_cnt  <= cur_len;
        end
    end

    // Mealy flags; a threshold of 0 behaves as 1, and reset forces them low
    always_comb begin
        thr_eff   = (threshold == '0) ? CNT_ONE : threshold;
        x         = reset & accept & (cur_len > CNT_ONE);
        y         = reset & accept & (cur_len >= thr_eff);
        run_len   = run_cnt;
        run_val   = last_val;
        dbg_state = (state == TRACK);
    end

endmodule

// File: doc/run_history_detector.md
# run_history_detector

Parametrised successor to the two-/three-in-a-row history FSM. It tracks the run length of identical input symbols over a WIDTH-bit stream with a per-sample valid qualifier. It raises a Mealy repeat flag `x` and a programmable-threshold run flag `y` in the same cycle as the qualifying sample. It sits at the front of the pattern-detection path and feeds downstream counters and alarms.

## Interface
- WIDTH, default 1: symbol width in bits.
- CNT_W, default 4: run-length counter width; maximum tracked run is 2^CNT_W-1.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; clears all state on assertion, independent of clk.
- a  input  WIDTH  input symbol, sampled only when valid=1.
- valid  input  1  qualifies `a` this cycle.
- clear  input  1  synchronous history flush; has priority over valid.
- threshold  input  CNT_W  run length at which `y` asserts; 0 is treated as 1. Must be held stable by software while valid traffic flows.
- x  output  1  Mealy: the current sample equals the previous accepted sample.
- y  output  1  Mealy: the current run length, including the current sample, is >= the effective threshold.
- run_len  output  CNT_W  registered length of the run ending at the last accepted sample; 0 when there is no history.
- run_val  output  WIDTH  registered last accepted symbol; 0 when there is no history.

## Operation
- States:
  - EMPTY: no history. Entered on reset and on clear.
  - TRACK: at least one sample has been accepted.
- Registers: state, last_val (WIDTH bits), run_cnt (CNT_W bits).
- Combinational current length cur_len, defined only when valid=1 and clear=0:
  - TRACK and a==last_val: cur_len = run_cnt+1, saturating at 2^CNT_W-1.
  - Otherwise: cur_len = 1.
- Outputs:
  - x = valid & ~clear & (cur_len >= 2).
  - y = valid & ~clear & (cur_len >= max(threshold,1)).
- Update on posedge clk:
  - clear=1: go to EMPTY, run_cnt=0, last_val=0.
  - Else valid=1: go to TRACK, last_val=a, run_cnt=cur_len.
  - Else (valid=0): hold all registers. A gap does not break a run.
- run_len = run_cnt; run_val = last_val.
- Saturation: once run_cnt = 2^CNT_W-1, further equal samples keep it at the maximum. x and y stay asserted. There is no wrap to 0.
- With WIDTH=1, threshold=3 and valid tied to 1, x and y must be bit-identical to the legacy two-/three-in-a-row FSM:
  - x asserts on two equal samples in a row.
  - y asserts on three equal samples in a row.
- The first sample after reset or clear never asserts x. It asserts y only when the effective threshold is 1.

## Timing
- Reset values (while reset=0): state=EMPTY, run_len=0, run_val=0. x=0 and y=0 whenever valid=0 or clear=1.
- x and y have zero latency: they are combinational from a, valid, clear, threshold and the registered state, and are valid in the same cycle as the sample.
- run_len and run_val reflect a sample from the cycle after it is accepted.
- Simultaneous clear and valid: the sample is discarded, x=y=0, and the next state is EMPTY.
- Reset asserted mid-run: outputs clear immediately and asynchronously. The first valid sample after reset deassertion is treated as a run of length 1.
- Threshold change: takes effect on y in the same cycle. It does not alter run_cnt.

## Test plan
- **Reset:**
  - Stimulus: hold reset=0 for 3 cycles with valid=1 and toggling a.
  - Required: x=0, y=0, run_len=0 and run_val=0 throughout, including between clock edges.
- **Legacy equivalence:**
  - Stimulus: WIDTH=1, threshold=3, valid=1, a = 0,0,0,1,1,0,0,0,0.
  - Required: x = 0,1,1,0,1,0,1,1,1; y = 0,0,1,0,0,0,0,1,1.
- **Saturation:**
  - Stimulus: CNT_W=4, WIDTH=8, threshold=15, 20 consecutive valid samples of 8'hA5.
  - Required: y first asserts on the 15th sample; run_len reaches 15 and stays at 15; y stays 1 through the 20th sample.
- **Valid gaps:**
  - Stimulus: valid samples 3,3; then 4 cycles with valid=0 and a=7; then a valid sample of 3, with threshold=3.
  - Required: x=0 and y=0 during the gap; run_len holds at 2; the third valid 3 gives x=1, y=1, and run_len=3 afterwards.
- **Clear collisions:**
  - Stimulus: a run of 5,5, then clear=1 together with valid=1 and a=5, then a valid sample of 5.
  - Required: x=y=0 in the clear cycle; run_len=0 after the clear cycle; the next sample gives x=0 and run_len=1.
- **Async reset mid-run and threshold 0:**
  - Stimulus: pulse reset low between clock edges during a run of length 4; then send valid samples with threshold=0.
  - Required: run_len drops to 0 immediately on reset; after reset, every valid sample asserts y=1, and the first sample has x=0.
